pdp_mem_arbiter: RTL and testbench
==================================

PDP_MEM_ARBITER -- requirements
Module: pdp_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of requesting channels (1..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, word-address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 12, data word width.
REQ-004 SHALL have parameter RD_LATENCY, default 1, cycles from mem_en to mem_rdata valid (1..4).
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 SHALL have port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port req, input, NUM_CH, per-channel request, held until granted.
REQ-009 SHALL have port we, input, NUM_CH, per-channel write (1) / read (0) select.
REQ-010 SHALL have port addr, input, NUM_CH*ADDR_WIDTH, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 SHALL have port wdata, input, NUM_CH*DATA_WIDTH, channel i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port gnt, output, NUM_CH, one-hot grant, same cycle as accepted request.
REQ-013 SHALL have port rvalid, output, NUM_CH, one-hot read-data-valid strobe.
REQ-014 SHALL have port rdata, output, DATA_WIDTH, shared read data, qualified by rvalid.
REQ-015 SHALL have ports mem_en, mem_we (output, 1), mem_addr (output, ADDR_WIDTH), mem_wdata (output, DATA_WIDTH), mem_rdata (input, DATA_WIDTH): single-port memory command and return.

Function
REQ-016 SHALL grant at most one channel per cycle; gnt is combinational from req and the priority pointer.
REQ-017 SHALL drive mem_en=1, mem_we/mem_addr/mem_wdata from the granted channel in the grant cycle; mem_en=0 and other mem_* = 0 when no grant.
REQ-018 SHALL arbitrate round-robin: search starts at (last_granted+1) mod NUM_CH; pointer updates only on a grant cycle.
REQ-019 SHALL accept a new grant every cycle (no bubbles); a sole requester is granted every cycle it requests.
REQ-020 SHALL track each granted read in a RD_LATENCY-deep tag pipeline (valid + channel id), in order.
REQ-021 SHALL assert rvalid[id] exactly RD_LATENCY cycles after the read's grant cycle, with rdata = mem_rdata that cycle; rvalid=0 and rdata=0 otherwise.
REQ-022 SHALL ignore a req deasserted before grant (no memory access, no rvalid).
REQ-023 SHALL produce no rvalid for writes; write occurs in the grant cycle.
REQ-024 SHALL, with NUM_CH=1, behave as a pass-through granting whenever req=1.

Reset
REQ-025 SHALL, on reset, set last_granted to NUM_CH-1 (channel 0 first priority), clear all tag-pipeline valids.
REQ-026 SHALL force gnt=0, mem_en=0 during reset cycles; rvalid=0 on the cycle after reset and until new reads mature.
REQ-027 SHALL discard in-flight reads on reset mid-operation (no rvalid ever emitted for them).

Configuration
REQ-028 SHALL, when PDP_ARB_WR_PRIORITY_EN is defined, grant any requesting writer before any reader, round-robin among writers using the same pointer; without it, pure round-robin regardless of we.

Verification
REQ-029 Reset, then req=3'b111 all reads held 3 cycles -> gnt 001,010,100 in order; rvalid same order, each RD_LATENCY cycles later.
REQ-030 Channel 1 only, reads to 12'o0100,12'o0101 back-to-back, RD_LATENCY=2 -> gnt[1] both cycles, rvalid[1] two consecutive cycles, rdata matching memory words.
REQ-031 Ch0 read + ch2 write 12'o7777 to 12'o0200 same cycle, macro undefined -> ch0 first; macro defined -> ch2 first, mem_we=1, mem_wdata=12'o7777.
REQ-032 Read granted, reset asserted next cycle (RD_LATENCY=3) -> no rvalid emitted; post-reset first grant to channel 0.
REQ-033 req[2] pulsed one cycle while ch0 granted, then dropped -> no access for ch2, pointer unaffected by ch2.

Source files
------------

// File: rtl/pdp_mem_arbiter.sv
// pdp_mem_arbiter: round-robin arbiter for a single-port memory with in-order read return.
// Define PDP_ARB_WR_PRIORITY_EN to serve requesting writers ahead of readers.
module pdp_mem_arbiter #(
  parameter int NUM_CH     = 3,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int RD_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            req,
  input  logic [NUM_CH-1:0]            we,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] wdata,
  output logic [NUM_CH-1:0]            gnt,
  output logic [NUM_CH-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  input  logic [DATA_WIDTH-1:0]        mem_rdata
);
  localparam int PW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [PW-1:0]            last_granted, sel, sel_hi, sel_lo;
  logic                     found_hi, found_lo, take, rd_take;
  logic [NUM_CH-1:0]        elig;
  logic [RD_LATENCY-1:0]    tag_vld;
  logic [RD_LATENCY*PW-1:0] tag_id;
  logic                     ret;
`ifdef PDP_ARB_WR_PRIORITY_EN
  assign elig = |(req & we) ? (req & we) : req;
`else
  assign elig = req;
`endif
  // Lowest eligible channel above the pointer wins, otherwise wrap to the lowest eligible overall.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    sel_hi = '0;
    sel_lo = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        found_lo = 1'b1;
        sel_lo = PW'(i);
      end
      if (elig[i] && i > int'(last_granted)) begin
        found_hi = 1'b1;
        sel_hi = PW'(i);
      end
    end
  end
  assign sel       = found_hi ? sel_hi : sel_lo;
  assign take      = found_lo && !reset;
  assign rd_take   = take && !we[sel];
  assign gnt       = take ? NUM_CH'(1) << sel : '0;
  assign mem_en    = take;
  assign mem_we    = take && we[sel];
  assign mem_addr  = take ? addr[sel*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign mem_wdata = take ? wdata[sel*DATA_WIDTH +: DATA_WIDTH] : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      last_granted <= PW'(NUM_CH - 1);
      tag_vld <= '0;
    end else begin
      if (take) last_granted <= sel;
      tag_vld <= RD_LATENCY'({tag_vld, rd_take});
    end
  end
  always_ff @(posedge clk) tag_id <= (RD_LATENCY*PW)'({tag_id, sel});
  // The oldest tag stage lines up with the memory's read return.
  assign ret    = tag_vld[RD_LATENCY-1] && !reset;
  assign rvalid = ret ? NUM_CH'(1) << tag_id[RD_LATENCY*PW-1 -: PW] : '0;
  assign rdata  = ret ? mem_rdata : '0;
endmodule

// File: tb/tb_pdp_mem_arbiter.sv
// tb_pdp_mem_arbiter: table-driven check of grants, memory command and read return (RD_LATENCY=2).
module tb_pdp_mem_arbiter;
  localparam int N = 3, AW = 12, DW = 12, LAT = 2;
  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0] req = '0, we = '0, gnt, rvalid;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata = {12'o7777, 12'o0002, 12'o0001};
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic mem_en, mem_we;
  logic [DW-1:0] pd [LAT];
  logic [LAT-1:0] pv = '0;
  int errs = 0, checks = 0;
  typedef struct {
    logic rst; logic [2:0] req, we; logic [11:0] a1;
    logic [2:0] gnt; logic mwe; logic [11:0] maddr, mwd; logic [2:0] rv; logic [11:0] rd;
  } vec_t;
  vec_t tbl [22];
  always #5 clk = ~clk;
  // Memory model: read word is the complement of its address, returned LAT cycles after mem_en.
  always @(posedge clk) begin
    pv <= LAT'({pv, mem_en & ~mem_we});
    pd[0] <= ~mem_addr;
    for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
  end
  assign mem_rdata = pv[LAT-1] ? pd[LAT-1] : 12'o1234;
  pdp_mem_arbiter #(.NUM_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s step %0d: got %0o want %0o", name, idx, act, exp);
    end
  endtask
  task automatic cyc(string tag, int idx, vec_t v);
    reset = v.rst;
    req = v.req;
    we = v.we;
    addr = {12'o0200, v.a1, 12'o0010};
    @(negedge clk);
    chk({tag, " gnt"}, idx, 32'(gnt), 32'(v.gnt));
    chk({tag, " mem_en"}, idx, 32'(mem_en), 32'(|v.gnt));
    chk({tag, " mem_we"}, idx, 32'(mem_we), 32'(v.mwe));
    chk({tag, " mem_addr"}, idx, 32'(mem_addr), 32'(v.maddr));
    chk({tag, " mem_wdata"}, idx, 32'(mem_wdata), 32'(v.mwd));
    chk({tag, " rvalid"}, idx, 32'(rvalid), 32'(v.rv));
    chk({tag, " rdata"}, idx, 32'(rdata), 32'(v.rd));
    @(posedge clk);
    #1;
  endtask
  initial begin
    //          rst   req     we      a1        gnt     mwe   maddr     mwdata    rv      rdata
    tbl[0]  = '{1'b1, 3'b111, 3'b000, 12'o0100, 3'b000, 1'b0, 12'o0000, 12'o0000, 3'b000, 12'o0000};
    tbl[1]  = '{1'b0, 3'b111, 3'b000, 12'o0100, 3'b001, 1'b0, 12'o0010, 12'o0001, 3'b000, 12'o0000};
    tbl[2]  = '{1'b0, 3'b111, 3'b000, 12'o0100, 3'b010, 1'b0, 12'o0100, 12'o0002, 3'b000, 12'o0000};
    tbl[3]  = '{1'b0, 3'b111, 3'b000, 12'o0100, 3'b100, 1'b0, 12'o0200, 12'o7777, 3'b001, 12'o7767};
    tbl[4]  = '{1'b0, 3'b000, 3'b000, 12'o0100, 3'b000, 1'b0, 12'o0000, 12'o0000, 3'b010, 12'o7677};
    tbl[5]  = '{1'b0, 3'b010, 3'b000, 12'o0100, 3'b010, 1'b0, 12'o0100, 12'o0002, 3'b100, 12'o7577};
    tbl[6]  = '{1'b0, 3'b010, 3'b000, 12'o0101, 3'b010, 1'b0, 12'o0101, 12'o0002, 3'b000, 12'o0000};
    tbl[7]  = '{1'b0, 3'b000, 3'b000, 12'o0101, 3'b000, 1'b0, 12'o0000, 12'o0000, 3'b010, 12'o7677};
    tbl[8]  = '{1'b0, 3'b000, 3'b000, 12'o0101, 3'b000, 1'b0, 12'o0000, 12'o0000, 3'b010, 12'o7676};
    tbl[9]  = '{1'b0, 3'b100, 3'b100, 12'o0101, 3'b100, 1'b1, 12'o0200, 12'o7777, 3'b000, 12'o0000};
    tbl[10] = '{1'b0, 3'b101, 3'b000, 12'o0101, 3'b001, 1'b0, 12'o0010, 12'o0001, 3'b000, 12'o0000};
    tbl[11] = '{1'b0, 3'b000, 3'b000, 12'o0101, 3'b000, 1'b0, 12'o0000, 12'o0000, 3'b000, 12'o0000};
    tbl[12] = '{1'b0, 3'b101, 3'b000, 12'o0101, 3'b100, 1'b0, 12'o0200, 12'o7777, 3'b001, 12'o7767};
    tbl[13] = '{1'b0, 3'b000, 3'b000, 12'o0101, 3'b000, 1'b0, 12'o0000, 12'o0000, 3'b000, 12'o0000};
    tbl[14] = '{1'b0, 3'b000, 3'b000, 12'o0101, 3'b000, 1'b0, 12'o0000, 12'o0000, 3'b100, 12'o7577};
    tbl[15] = '{1'b0, 3'b001, 3'b000, 12'o0101, 3'b001, 1'b0, 12'o0010, 12'o0001, 3'b000, 12'o0000};
    tbl[16] = '{1'b1, 3'b001, 3'b000, 12'o0101, 3'b000, 1'b0, 12'o0000, 12'o0000, 3'b000, 12'o0000};
    tbl[17] = '{1'b0, 3'b000, 3'b000, 12'o0101, 3'b000, 1'b0, 12'o0000, 12'o0000, 3'b000, 12'o0000};
    tbl[18] = '{1'b0, 3'b000, 3'b000, 12'o0101, 3'b000, 1'b0, 12'o0000, 12'o0000, 3'b000, 12'o0000};
    tbl[19] = '{1'b0, 3'b011, 3'b000, 12'o0101, 3'b001, 1'b0, 12'o0010, 12'o0001, 3'b000, 12'o0000};
    tbl[20] = '{1'b0, 3'b000, 3'b000, 12'o0101, 3'b000, 1'b0, 12'o0000, 12'o0000, 3'b000, 12'o0000};
    tbl[21] = '{1'b0, 3'b000, 3'b000, 12'o0101, 3'b000, 1'b0, 12'o0000, 12'o0000, 3'b001, 12'o7767};
    addr = {12'o0200, 12'o0100, 12'o0010};
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 22; i++) cyc("tbl", i, tbl[i]);
    // Simultaneous ch0 read and ch2 write from a fresh reset.
    cyc("wr", 0, '{1'b1, 3'b000, 3'b000, 12'o0101, 3'b000, 1'b0, 12'o0000, 12'o0000, 3'b000, 12'o0000});
`ifdef PDP_ARB_WR_PRIORITY_EN
    cyc("wr", 1, '{1'b0, 3'b101, 3'b100, 12'o0101, 3'b100, 1'b1, 12'o0200, 12'o7777, 3'b000, 12'o0000});
    cyc("wr", 2, '{1'b0, 3'b001, 3'b000, 12'o0101, 3'b001, 1'b0, 12'o0010, 12'o0001, 3'b000, 12'o0000});
    cyc("wr", 3, '{1'b0, 3'b000, 3'b000, 12'o0101, 3'b000, 1'b0, 12'o0000, 12'o0000, 3'b000, 12'o0000});
    cyc("wr", 4, '{1'b0, 3'b000, 3'b000, 12'o0101, 3'b000, 1'b0, 12'o0000, 12'o0000, 3'b001, 12'o7767});
`else
    cyc("wr", 1, '{1'b0, 3'b101, 3'b100, 12'o0101, 3'b001, 1'b0, 12'o0010, 12'o0001, 3'b000, 12'o0000});
    cyc("wr", 2, '{1'b0, 3'b100, 3'b100, 12'o0101, 3'b100, 1'b1, 12'o0200, 12'o7777, 3'b000, 12'o0000});
    cyc("wr", 3, '{1'b0, 3'b000, 3'b000, 12'o0101, 3'b000, 1'b0, 12'o0000, 12'o0000, 3'b001, 12'o7767});
    cyc("wr", 4, '{1'b0, 3'b000, 3'b000, 12'o0101, 3'b000, 1'b0, 12'o0000, 12'o0000, 3'b000, 12'o0000});
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
